// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO responder: I/O page layout
// and default page base address.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

    localparam logic [31:0] OFF_LED    = 32'h0000_0000;
    localparam logic [31:0] OFF_SW     = 32'h0000_0004;
    localparam logic [31:0] OFF_KEYS   = 32'h0000_0008;
    localparam logic [31:0] OFF_CYCLE  = 32'h0000_000C;
    localparam logic [31:0] OFF_TIMER  = 32'h0000_0010;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0014;

endpackage

// File: rtl/sync_fall.sv
// Two-flop synchronizer for one asynchronous input, plus a one-cycle pulse
// when the synchronized value falls from 1 to 0.
module sync_fall #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic fall
);

    logic s1, s2, s3;

    // s3 only remembers the previous synchronized value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side load/store responder: word RAM plus an I/O page with LEDs,
// switches, sticky key flags, a cycle counter and a one-shot down timer.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int unsigned NSW       = 10,
    parameter int unsigned NKEYS     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    input  logic [NSW-1:0]   sw,
    input  logic [NKEYS-1:0] key_n,
    output logic [NSW-1:0]   leds
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [31:0]      word_addr;
    logic [AW-1:0]    ram_idx;
    logic             is_ram;
    logic             hit_led, hit_sw, hit_keys, hit_cycle, hit_timer, hit_status;
    logic             we_led, we_timer, we_status;
    logic [NKEYS-1:0] key_clr;
    logic             expire;

    logic [31:0]      ram [DEPTH] = '{default: 32'h0};
    logic [NSW-1:0]   led_q;
    logic [NKEYS-1:0] keys_q;
    logic [31:0]      cycle_cnt;
    logic [31:0]      timer_q;
    logic             expired_q;

    logic [NSW-1:0]   sw_sync, sw_fall;
    logic [NKEYS-1:0] key_sync, key_fall;
    logic             unused_bits;

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        sync_fall #(.RESET_VAL(1'b0)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (sw[i]),
            .q     (sw_sync[i]),
            .fall  (sw_fall[i])
        );
    end

    // Keys idle high, so their synchronizers reset to 1 to avoid a false press.
    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        sync_fall #(.RESET_VAL(1'b1)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (key_n[i]),
            .q     (key_sync[i]),
            .fall  (key_fall[i])
        );
    end

    assign unused_bits = ^{ALUResult[1:0], sw_fall, key_sync};

    assign word_addr  = {ALUResult[31:2], 2'b00};
    assign ram_idx    = ALUResult[AW+1:2];
    assign is_ram     = word_addr < RAM_BYTES;
    assign hit_led    = word_addr == MMIO_BASE + OFF_LED;
    assign hit_sw     = word_addr == MMIO_BASE + OFF_SW;
    assign hit_keys   = word_addr == MMIO_BASE + OFF_KEYS;
    assign hit_cycle  = word_addr == MMIO_BASE + OFF_CYCLE;
    assign hit_timer  = word_addr == MMIO_BASE + OFF_TIMER;
    assign hit_status = word_addr == MMIO_BASE + OFF_STATUS;

    assign we_led    = MemWrite && hit_led;
    assign we_timer  = MemWrite && hit_timer;
    assign we_status = MemWrite && hit_status && WriteData[0];
    assign key_clr   = (MemWrite && hit_keys) ? WriteData[NKEYS-1:0] : '0;
    // Expiry only on a natural 1->0 step; a load (even of 0) never flags it.
    assign expire    = !we_timer && (timer_q == 32'd1);

    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            keys_q    <= '0;
            cycle_cnt <= '0;
            timer_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (we_led) begin
                led_q <= WriteData[NSW-1:0];
            end
            keys_q    <= (keys_q & ~key_clr) | key_fall;
            if (we_timer) begin
                timer_q <= WriteData;
            end else if (timer_q != 32'd0) begin
                timer_q <= timer_q - 32'd1;
            end
            expired_q <= (expired_q & ~we_status) | expire;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (is_ram) begin
            ReadData = ram[ram_idx];
        end else if (hit_led) begin
            ReadData = 32'(led_q);
        end else if (hit_sw) begin
            ReadData = 32'(sw_sync);
        end else if (hit_keys) begin
            ReadData = 32'(keys_q);
        end else if (hit_cycle) begin
            ReadData = cycle_cnt;
        end else if (hit_timer) begin
            ReadData = timer_q;
        end else if (hit_status) begin
            ReadData = {31'h0, expired_q};
        end
    end

    assign leds = led_q;

endmodule
